// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA modular exponentiation core:
// register-select codes, FSM states and the fixed operation latency.
package rsa_pkg;

    localparam logic [1:0] SEL_C = 2'd0;
    localparam logic [1:0] SEL_N = 2'd1;
    localparam logic [1:0] SEL_E = 2'd2;
    localparam logic [1:0] SEL_M = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_MUL,
        ST_WAIT,
        ST_NEXT,
        ST_DONE
    } state_t;

    // Cycles from the accepting start edge until ready rises again.
    function automatic int unsigned rsa_lat(input int unsigned key_w);
        return key_w * (key_w + 3) + 3;
    endfunction

endpackage

// File: rtl/rsa_modexp_if.sv
// Byte-wide host port of the RSA core: register access, start and status.
interface rsa_modexp_if #(
    parameter int ADDR_W = 5
);
    logic              we;
    logic              oe;
    logic              start;
    logic [1:0]        reg_sel;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data_i;
    logic [7:0]        data_o;
    logic              ready;
    logic              done;

    modport master (
        output we, oe, start, reg_sel, addr, data_i,
        input  data_o, ready, done
    );

    modport slave (
        input  we, oe, start, reg_sel, addr, data_i,
        output data_o, ready, done
    );
endinterface

// File: rtl/rsa_modmul.sv
// Bit-serial interleaved (Blakley) modular multiplier: result = a*b mod n.
// Takes KEY_W cycles from the start edge; done pulses for one cycle after.
module rsa_modmul
    import rsa_pkg::*;
#(
    parameter int KEY_W = 256
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [KEY_W-1:0] a,
    input  logic [KEY_W-1:0] b,
    input  logic [KEY_W-1:0] n,
    output logic [KEY_W-1:0] result,
    output logic             done
);
    localparam int CW = $clog2(KEY_W);

    logic [KEY_W+1:0] acc;
    logic [KEY_W-1:0] a_sh;
    logic [KEY_W-1:0] b_q;
    logic [KEY_W-1:0] n_q;
    logic [CW-1:0]    cnt;
    logic             busy;

    logic [KEY_W+1:0] acc_src;
    logic [KEY_W+1:0] b_ext;
    logic [KEY_W+1:0] n_ext;
    logic [KEY_W+1:0] sum;
    logic [KEY_W+1:0] red1;
    logic [KEY_W+1:0] red2;
    logic             a_bit;

    // The first step runs on the start edge itself, so the operands come
    // straight from the ports there and from the latched copies afterwards.
    always_comb begin
        acc_src = start ? '0 : acc;
        a_bit   = start ? a[KEY_W-1] : a_sh[KEY_W-1];
        b_ext   = {2'b00, (start ? b : b_q)};
        n_ext   = {2'b00, (start ? n : n_q)};
        sum     = (acc_src << 1) + (a_bit ? b_ext : '0);
        red1    = (sum >= n_ext) ? sum - n_ext : sum;
        red2    = (red1 >= n_ext) ? red1 - n_ext : red1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc  <= '0;
            a_sh <= '0;
            b_q  <= '0;
            n_q  <= '0;
            cnt  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else if (start) begin
            acc  <= red2;
            a_sh <= a << 1;
            b_q  <= b;
            n_q  <= n;
            cnt  <= CW'(KEY_W - 1);
            busy <= 1'b1;
            done <= 1'b0;
        end else if (busy) begin
            acc  <= red2;
            a_sh <= a_sh << 1;
            cnt  <= cnt - 1'b1;
            if (cnt == CW'(1)) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
        end else begin
            done <= 1'b0;
        end
    end

    assign result = acc[KEY_W-1:0];

endmodule

// File: rtl/rsa_modexp_core.sv
// RSA engine C = M^E mod N: byte register file plus a constant-time
// right-to-left square-and-multiply sequencer over two Blakley multipliers.
module rsa_modexp_core
    import rsa_pkg::*;
#(
    parameter int KEY_W  = 256,
    parameter int ADDR_W = $clog2(KEY_W / 8)
) (
    input  logic         clk,
    input  logic         reset,
    rsa_modexp_if.slave  bus
);
    localparam int IDXW = $clog2(KEY_W);

    logic [KEY_W-1:0] n_reg, e_reg, m_reg, c_reg;
    logic [KEY_W-1:0] nw, ew, s_reg, r_reg;
    logic [IDXW-1:0]  idx;
    state_t           state;
    logic             mul_start;
    logic [KEY_W-1:0] mul_r_res, mul_s_res;
    logic             mul_r_done, mul_s_done;
    logic [ADDR_W+2:0] bit_off;

    assign bit_off = {bus.addr, 3'b000};

    rsa_modmul #(.KEY_W(KEY_W)) mul_r (
        .clk    (clk),
        .reset  (reset),
        .start  (mul_start),
        .a      (r_reg),
        .b      (s_reg),
        .n      (nw),
        .result (mul_r_res),
        .done   (mul_r_done)
    );

    rsa_modmul #(.KEY_W(KEY_W)) mul_s (
        .clk    (clk),
        .reset  (reset),
        .start  (mul_start),
        .a      (s_reg),
        .b      (s_reg),
        .n      (nw),
        .result (mul_s_res),
        .done   (mul_s_done)
    );

    // Host register file; C is read-only and only the sequencer updates it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            n_reg      <= '0;
            e_reg      <= '0;
            m_reg      <= '0;
            bus.data_o <= '0;
        end else begin
            if (bus.we && bus.ready) begin
                case (bus.reg_sel)
                    SEL_N:   n_reg[bit_off +: 8] <= bus.data_i;
                    SEL_E:   e_reg[bit_off +: 8] <= bus.data_i;
                    SEL_M:   m_reg[bit_off +: 8] <= bus.data_i;
                    default: ;
                endcase
            end
            if (bus.oe) begin
                case (bus.reg_sel)
                    SEL_C:   bus.data_o <= c_reg[bit_off +: 8];
                    SEL_N:   bus.data_o <= n_reg[bit_off +: 8];
                    SEL_E:   bus.data_o <= e_reg[bit_off +: 8];
                    default: bus.data_o <= m_reg[bit_off +: 8];
                endcase
            end
        end
    end

    // Both products are computed every round whatever the exponent bit, so
    // the latency never depends on E. IDLE with ready low is the cycle in
    // which the done pulse is visible.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            bus.ready <= 1'b1;
            bus.done  <= 1'b0;
            c_reg     <= '0;
            nw        <= '0;
            ew        <= '0;
            s_reg     <= '0;
            r_reg     <= '0;
            idx       <= '0;
            mul_start <= 1'b0;
        end else begin
            mul_start <= 1'b0;
            bus.done  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!bus.ready) begin
                        bus.ready <= 1'b1;
                    end else if (bus.start) begin
                        nw        <= n_reg;
                        ew        <= e_reg;
                        s_reg     <= m_reg;
                        r_reg     <= KEY_W'(1);
                        idx       <= '0;
                        bus.ready <= 1'b0;
                        state     <= ST_LOAD;
                    end
                end
                ST_LOAD: state <= ST_MUL;
                ST_MUL: begin
                    mul_start <= 1'b1;
                    state     <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (mul_r_done && mul_s_done) state <= ST_NEXT;
                end
                ST_NEXT: begin
                    s_reg <= mul_s_res;
                    if (ew[idx]) r_reg <= mul_r_res;
                    idx   <= idx + 1'b1;
                    state <= (idx == IDXW'(KEY_W - 1)) ? ST_DONE : ST_MUL;
                end
                ST_DONE: begin
                    c_reg    <= r_reg;
                    bus.done <= 1'b1;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_modexp_core.sv
// Scoreboard bench for rsa_modexp_core: KEY_W=16 functional runs against a
// left-to-right power model, plus a KEY_W=256 instance for mid-op reset.
module tb_rsa_modexp_core;
    import rsa_pkg::*;

    localparam int KS    = 16;
    localparam int KB    = 256;
    localparam int LAT_S = rsa_lat(KS);

    typedef struct {
        string      name;
        logic [7:0] exp;
    } rd_t;

    logic       clk = 1'b0;
    logic       rst_s, rst_b;
    logic       we, oe, start;
    logic [1:0] reg_sel;
    logic [4:0] addr;
    logic [7:0] data_i;
    bit         use_big = 1'b0;

    rd_t         rd_q[$];
    int unsigned start_q[$];
    int          errors = 0;
    int          checks = 0;
    int unsigned cycle = 0;
    int          done_s_cnt = 0;
    int          done_b_cnt = 0;
    int          starts_s = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    rsa_modexp_if #(.ADDR_W(1)) bus_s ();
    rsa_modexp_if #(.ADDR_W(5)) bus_b ();

    assign bus_s.we = we;      assign bus_b.we = we;
    assign bus_s.oe = oe;      assign bus_b.oe = oe;
    assign bus_s.start = start; assign bus_b.start = start;
    assign bus_s.reg_sel = reg_sel; assign bus_b.reg_sel = reg_sel;
    assign bus_s.addr = addr[0]; assign bus_b.addr = addr;
    assign bus_s.data_i = data_i; assign bus_b.data_i = data_i;

    rsa_modexp_core #(.KEY_W(KS)) dut_s (.clk(clk), .reset(rst_s), .bus(bus_s));
    rsa_modexp_core #(.KEY_W(KB)) dut_b (.clk(clk), .reset(rst_b), .bus(bus_b));

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Square-and-multiply from the most significant exponent bit down.
    function automatic logic [15:0] model_pow(input longint unsigned n, input logic [15:0] e,
                                              input longint unsigned m);
        longint unsigned r = 1;
        for (int i = 15; i >= 0; i--) begin
            r = (r * r) % n;
            if (e[i]) r = (r * m) % n;
        end
        return r[15:0];
    endfunction

    // Monitor: compares read data and checks each done pulse against the queues.
    initial begin
        bit          rd, rd_big, ready_chk;
        rd_t         e;
        int unsigned a;
        ready_chk = 1'b0;
        forever begin
            @(posedge clk);
            rd     = oe;
            rd_big = use_big;
            @(negedge clk);
            if (rd) begin
                check_output("read expected", 32'(rd_q.size() > 0), 1);
                if (rd_q.size() > 0) begin
                    e = rd_q.pop_front();
                    check_output(e.name, rd_big ? bus_b.data_o : bus_s.data_o, e.exp);
                end
            end
            if (bus_s.done) begin
                done_s_cnt++;
                check_output("done expected", 32'(start_q.size() > 0), 1);
                if (start_q.size() > 0) begin
                    a = start_q.pop_front();
                    check_output("done latency", cycle - a, LAT_S);
                    check_output("ready low during done", bus_s.ready, 0);
                    ready_chk = 1'b1;
                end
            end else if (ready_chk) begin
                check_output("ready after done", bus_s.ready, 1);
                ready_chk = 1'b0;
            end
            if (bus_b.done) done_b_cnt++;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic write_byte(input logic [1:0] sel, input int a, input logic [7:0] d);
        reg_sel = sel; addr = a[4:0]; data_i = d; we = 1'b1;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic write16(input logic [1:0] sel, input logic [15:0] v);
        write_byte(sel, 0, v[7:0]);
        write_byte(sel, 1, v[15:8]);
    endtask

    task automatic read_exp(input logic [1:0] sel, input int a, input logic [7:0] exp, input string name);
        rd_t r;
        r.name = name; r.exp = exp;
        reg_sel = sel; addr = a[4:0]; oe = 1'b1;
        rd_q.push_back(r);
        @(negedge clk);
        oe = 1'b0;
    endtask

    task automatic read16(input logic [1:0] sel, input logic [15:0] v, input string name);
        read_exp(sel, 0, v[7:0], {name, " byte0"});
        read_exp(sel, 1, v[15:8], {name, " byte1"});
    endtask

    task automatic start_op();
        start = 1'b1;
        start_q.push_back(cycle);
        starts_s++;
        @(negedge clk);
        start = 1'b0;
        check_output("busy after start", bus_s.ready, 0);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!bus_s.ready && n < LAT_S + 20) begin
            @(negedge clk);
            n++;
        end
        check_output("ready returns", bus_s.ready, 1);
    endtask

    task automatic apply_stimulus(input logic [15:0] n, input logic [15:0] e, input logic [15:0] m,
                                  input logic [15:0] c, input string name);
        write16(SEL_N, n);
        write16(SEL_E, e);
        write16(SEL_M, m);
        start_op();
        wait_ready();
        read16(SEL_C, c, name);
    endtask

    initial begin
        logic [15:0] rn, re, rm;
        we = 0; oe = 0; start = 0; reg_sel = 0; addr = 0; data_i = 0;
        rst_s = 1'b0; rst_b = 1'b0;
        repeat (3) @(negedge clk);
        rst_s = 1'b1;
        @(negedge clk);
        check_output("reset ready", bus_s.ready, 1);
        check_output("reset done", bus_s.done, 0);
        check_output("reset data_o", bus_s.data_o, 0);
        for (int s = 0; s < 4; s++) read16(2'(s), 16'h0000, "reset readback");

        apply_stimulus(16'd3233, 16'd17, 16'd65, 16'd2790, "encrypt C");
        apply_stimulus(16'd3233, 16'd2753, 16'd2790, 16'd65, "decrypt C");

        // E=0 with writes and a second start attempted while busy.
        write16(SEL_E, 16'd0);
        start_op();
        read16(SEL_C, 16'd65, "C holds while busy");
        write16(SEL_N, 16'hFFFF);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_ready();
        read16(SEL_C, 16'd1, "E=0 C");
        read16(SEL_N, 16'd3233, "N after busy write");
        check_output("one done per start", done_s_cnt, 3);

        // Write to M in the very cycle start is accepted.
        write16(SEL_E, 16'd17);
        write16(SEL_M, 16'd65);
        reg_sel = SEL_M; addr = 0; data_i = 8'h02; we = 1'b1; start = 1'b1;
        start_q.push_back(cycle);
        starts_s++;
        @(negedge clk);
        we = 1'b0; start = 1'b0;
        wait_ready();
        read16(SEL_C, 16'd2790, "start+write C");
        read16(SEL_M, 16'd2, "start+write M");

        apply_stimulus(16'd3233, 16'hFFFF, 16'd65, model_pow(3233, 16'hFFFF, 65), "E all ones C");
        apply_stimulus(16'd3233, 16'd5, 16'd0, 16'd0, "M=0 C");
        for (int i = 0; i < 6; i++) begin
            rn = 16'($urandom_range(65535, 2));
            re = 16'($urandom_range(65535, 0));
            rm = 16'($urandom_range(int'(rn) - 1, 0));
            apply_stimulus(rn, re, rm, model_pow(rn, re, rm), "random C");
        end
        check_output("done count", done_s_cnt, starts_s);

        // Mid-operation reset on the full-width instance.
        rst_s = 1'b0;
        use_big = 1'b1;
        rst_b = 1'b1;
        @(negedge clk);
        for (int b = 0; b < KB / 8; b++) begin
            write_byte(SEL_N, b, (b == KB / 8 - 1) ? 8'hC1 : 8'($urandom));
            write_byte(SEL_E, b, 8'($urandom));
            write_byte(SEL_M, b, (b == KB / 8 - 1) ? 8'h11 : 8'($urandom));
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_output("big busy", bus_b.ready, 0);
        repeat (1000) @(negedge clk);
        rst_b = 1'b0;
        #1;
        check_output("abort ready", bus_b.ready, 1);
        check_output("abort done", bus_b.done, 0);
        check_output("abort data_o", bus_b.data_o, 0);
        @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        for (int s = 0; s < 4; s++)
            for (int b = 0; b < KB / 8; b++) read_exp(2'(s), b, 8'h00, "abort readback");
        repeat (300) @(negedge clk);
        check_output("no done after abort", done_b_cnt, 0);
        check_output("read queue drained", rd_q.size(), 0);
        check_output("done queue drained", start_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
